// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin selection of up to CDB_WIDTH functional-unit results per cycle
// onto registered common-data-bus slots, with squash drain and synchronous reset.
module cdb_arbiter #(
   parameter int NUM_FU    = 6,
   parameter int CDB_WIDTH = 2,
   parameter int VALUE_W   = 32,
   parameter int PRF_W     = 6,
   parameter int ROB_W     = 5,
   parameter int ADDR_W    = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_FU-1:0]    fu_valid,
   input  logic [VALUE_W-1:0]   fu_value [NUM_FU],
   input  logic                 fu_value_valid [NUM_FU],
   input  logic [PRF_W-1:0]     fu_dest_prf [NUM_FU],
   input  logic [ROB_W-1:0]     fu_rob_entry [NUM_FU],
   input  logic [ADDR_W-1:0]    fu_branch_address [NUM_FU],
   input  logic                 squash,
   output logic [NUM_FU-1:0]    sel,
   output logic [CDB_WIDTH-1:0] cdb_valid,
   output logic [VALUE_W-1:0]   cdb_value [CDB_WIDTH],
   output logic                 cdb_value_valid [CDB_WIDTH],
   output logic [PRF_W-1:0]     cdb_dest_prf [CDB_WIDTH],
   output logic [ROB_W-1:0]     cdb_rob_entry [CDB_WIDTH],
   output logic [ADDR_W-1:0]    cdb_branch_address [CDB_WIDTH]
);
   localparam int PTR_W = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
   localparam int CNT_W = $clog2(CDB_WIDTH + 1);
   logic [PTR_W-1:0] rr_ptr, last, idx, next_ptr;
   logic [PTR_W-1:0] slot_idx [CDB_WIDTH];
   logic [CDB_WIDTH-1:0] slot_hit;
   logic [NUM_FU-1:0] grant;
   logic [CNT_W-1:0] cnt;
   // scan from rr_ptr with wrap; cnt-th grant lands in slot cnt
   always_comb begin
      grant = '0;
      slot_hit = '0;
      cnt = '0;
      last = rr_ptr;
      idx = '0;
      for (int k = 0; k < CDB_WIDTH; k++) slot_idx[k] = '0;
      for (int j = 0; j < NUM_FU; j++) begin
         idx = PTR_W'((int'(rr_ptr) + j) % NUM_FU);
         if (fu_valid[idx] && int'(cnt) < CDB_WIDTH) begin
            grant[idx] = 1'b1;
            for (int k = 0; k < CDB_WIDTH; k++)
               if (int'(cnt) == k) begin
                  slot_idx[k] = idx;
                  slot_hit[k] = 1'b1;
               end
            last = idx;
            cnt = cnt + CNT_W'(1);
         end
      end
   end
   assign sel = reset ? '0 : squash ? fu_valid : grant;
   assign next_ptr = (last == PTR_W'(NUM_FU - 1)) ? '0 : last + PTR_W'(1);
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr <= '0;
         cdb_valid <= '0;
         for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_value[k] <= '0;
            cdb_value_valid[k] <= 1'b0;
            cdb_dest_prf[k] <= '0;
            cdb_rob_entry[k] <= '0;
            cdb_branch_address[k] <= '0;
         end
      end else begin
         if (!squash && |grant) rr_ptr <= next_ptr;
         for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_valid[k] <= slot_hit[k] && !squash;
            cdb_value[k] <= fu_value[slot_idx[k]];
            cdb_value_valid[k] <= fu_value_valid[slot_idx[k]];
            cdb_dest_prf[k] <= fu_dest_prf[slot_idx[k]];
            cdb_rob_entry[k] <= fu_rob_entry[slot_idx[k]];
            cdb_branch_address[k] <= fu_branch_address[slot_idx[k]];
         end
      end
   end
endmodule
